// File: rtl/io_input_cond.sv
// io_input_cond: synchronise, debounce and edge-detect board inputs, and derive a stretched system reset
// Ports: clk_i/rst_i clock and synchronous active-high reset; raw_i asynchronous switch/key inputs;
//   level_o debounced levels; rise_o/fall_o one-cycle debounced edge pulses; any_edge_o OR of all pulses;
//   sys_rst_o registered downstream reset (rst_i or long press of RST_CH, stretched by RST_STRETCH cycles).
module io_input_cond #(
  parameter int                NUM_CH      = 22,
  parameter int                SYNC_STAGES = 2,
  parameter int unsigned       DB_CYCLES   = 32'h500000,
  parameter logic [NUM_CH-1:0] INIT_VAL    = '0,
  parameter int                RST_CH      = 17,
  parameter int unsigned       RST_HOLD    = 32'h500000,
  parameter int unsigned       RST_STRETCH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] raw_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic              any_edge_o,
  output logic              sys_rst_o
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int HW = RST_HOLD < 1 ? 1 : $clog2(RST_HOLD + 1);
  localparam int SW = RST_STRETCH < 1 ? 1 : $clog2(RST_STRETCH + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);
  localparam logic [SW-1:0] ST_INIT  = SW'(RST_STRETCH);
  logic [NUM_CH-1:0] sync [SYNC_STAGES];
  logic [CW-1:0]     cnt [NUM_CH];
  logic [NUM_CH-1:0] synced, acc;
  logic [HW-1:0]     hold;
  logic [SW-1:0]     stretch;
  logic              cause;
  assign synced = sync[SYNC_STAGES-1];
  // acc marks channels whose new level has persisted long enough to be accepted this cycle
  always_comb begin
    acc = '0;
    for (int c = 0; c < NUM_CH; c++) acc[c] = (synced[c] != level_o[c]) && (cnt[c] == DB_LAST);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= INIT_VAL;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      level_o    <= INIT_VAL;
      rise_o     <= '0;
      fall_o     <= '0;
      any_edge_o <= 1'b0;
    end else begin
      sync[0] <= raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= (synced[c] == level_o[c] || acc[c]) ? '0 : cnt[c] + CW'(1);
      level_o    <= (level_o & ~acc) | (synced & acc);
      rise_o     <= acc & synced;
      fall_o     <= acc & ~synced;
      any_edge_o <= |acc;
    end
  end
  // hold keeps counting through its own sys_rst_o; only rst_i or a released RST_CH clears it
  assign cause = rst_i || (hold == HOLD_MAX);
  always_ff @(posedge clk_i) begin
    hold      <= (rst_i || !level_o[RST_CH]) ? '0 : (hold == HOLD_MAX) ? hold : hold + HW'(1);
    stretch   <= cause ? ST_INIT : stretch - SW'(stretch != '0);
    sys_rst_o <= cause || (stretch != '0);
  end
endmodule
